// File: rtl/hc4040_gen_if.sv
// Purpose : control/status bundle for the hc4040_gen counter (everything except clock and reset).
// Latency : n/a (wiring only).
// Backpres: none; the counter samples the controls on every falling clock edge.
//
// Signals:
//   ce, up, ld, d, clr_ovf  - controls driven by the user (master)
//   q, tc, co, ovf          - counter state and flags driven by the counter (slave)
interface hc4040_gen_if #(
    parameter int WIDTH = 12
);
    logic             ce;
    logic             up;
    logic             ld;
    logic [WIDTH-1:0] d;
    logic             clr_ovf;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             co;
    logic             ovf;

    // User side: drives the controls and observes the counter.
    modport master (
        output ce, up, ld, d, clr_ovf,
        input  q, tc, co, ovf
    );

    // Counter side.
    modport slave (
        input  ce, up, ld, d, clr_ovf,
        output q, tc, co, ovf
    );
endinterface

// File: rtl/hc4040_gen.sv
// Purpose : generic-width, generic-modulus binary counter with enable, up/down, load, wrap pulse, sticky overflow.
// Latency : q/co/ovf update on the falling edge of p10 after the controls; tc is combinational on q, ce, up.
// Backpres: none; the counter accepts a new control set on every falling edge.
//
// Ports:
//   p10       - clock, all state changes on its falling edge
//   p11       - synchronous active-high reset (overrides load, count and clr_ovf)
//   bus.ce    - count enable          bus.up  - 1 = count up, 0 = count down
//   bus.ld    - parallel load of d (clamped to the top count)
//   bus.clr_ovf - clears the sticky ovf flag on an edge without a wrap
//   bus.q     - counter value         bus.tc  - terminal count (for cascading into the next ce)
//   bus.co    - one-period pulse following a wrap edge
//   bus.ovf   - sticky wrap flag
module hc4040_gen #(
    parameter int              WIDTH       = 12,
    parameter longint unsigned MODULUS     = 0,
    parameter longint unsigned RESET_VALUE = 0
) (
    input  logic         p10,
    input  logic         p11,
    hc4040_gen_if.slave  bus
);

    // Effective sequence length; 0 selects the full 2^WIDTH range.
    localparam longint unsigned M_EFF      = (MODULUS == 0) ? (64'd1 << WIDTH) : MODULUS;
    localparam logic [WIDTH-1:0] TOP       = WIDTH'(M_EFF - 64'd1);
    localparam logic [WIDTH-1:0] RST_Q     = WIDTH'(RESET_VALUE);
    localparam bit               FULL_RANGE = (MODULUS == 0);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             co_q,  co_d;
    logic             ovf_q, ovf_d;

    logic             at_top;
    logic             at_zero;
    logic             wrap_cond;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;
    logic [WIDTH-1:0] load_val;

    assign at_top    = (cnt_q == TOP);
    assign at_zero   = (cnt_q == '0);

    // The edge would wrap if it counts in the current direction from the end of the range.
    assign wrap_cond = bus.up ? at_top : at_zero;

    // Deliberately ignores ld: tc is a pure function of live ce/up and q so that a
    // cascaded stage sees a clean enable one period before the wrap.
    assign bus.tc    = bus.ce & wrap_cond;

    // With the full binary range the natural WIDTH-bit rollover already produces
    // TOP -> 0, so no comparator sits on the up path.
    generate
        if (FULL_RANGE) begin : g_inc_full
            assign inc_val = cnt_q + WIDTH'(1);
        end else begin : g_inc_mod
            assign inc_val = at_top ? '0 : (cnt_q + WIDTH'(1));
        end
    endgenerate

    // 0 -> TOP; in the full-range case TOP is all ones, identical to natural rollover.
    assign dec_val  = at_zero ? TOP : (cnt_q - WIDTH'(1));

    // Out-of-range load data saturates at the top count instead of wrapping.
    assign load_val = (bus.d > TOP) ? TOP : bus.d;

    always_comb begin
        cnt_d = cnt_q;
        co_d  = 1'b0;
        ovf_d = ovf_q & ~bus.clr_ovf;
        if (bus.ld) begin
            cnt_d = load_val;
        end else if (bus.ce) begin
            cnt_d = bus.up ? inc_val : dec_val;
            if (wrap_cond) begin
                co_d  = 1'b1;
                // Set wins over a simultaneous clr_ovf.
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(negedge p10) begin
        if (p11) begin
            cnt_q <= RST_Q;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            co_q  <= co_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.q   = cnt_q;
    assign bus.co  = co_q;
    assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_hc4040_gen.sv
// Purpose : scoreboard bench for hc4040_gen: 12-bit full range, 4-bit modulo-10, and a 2x4-bit cascade.
// Latency : expectations pushed before each falling edge, popped and compared just after it.
// Backpres: n/a.
module tb_hc4040_gen;

    logic clk;
    logic rst_a, rst_b, rst_c;

    hc4040_gen_if #(.WIDTH(12)) ifa ();
    hc4040_gen_if #(.WIDTH(4))  ifb ();
    hc4040_gen_if #(.WIDTH(4))  iflo ();
    hc4040_gen_if #(.WIDTH(4))  ifhi ();

    hc4040_gen #(.WIDTH(12), .MODULUS(0),  .RESET_VALUE(0)) dut_a  (.p10(clk), .p11(rst_a), .bus(ifa));
    hc4040_gen #(.WIDTH(4),  .MODULUS(10), .RESET_VALUE(0)) dut_b  (.p10(clk), .p11(rst_b), .bus(ifb));
    hc4040_gen #(.WIDTH(4),  .MODULUS(0),  .RESET_VALUE(0)) dut_lo (.p10(clk), .p11(rst_c), .bus(iflo));
    hc4040_gen #(.WIDTH(4),  .MODULUS(0),  .RESET_VALUE(0)) dut_hi (.p10(clk), .p11(rst_c), .bus(ifhi));

    // High stage advances only when the low stage is about to wrap.
    assign ifhi.ce = iflo.tc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint unsigned q;
        bit              co;
        bit              ovf;
    } st_t;

    typedef struct {
        int              id;
        longint unsigned q;
        bit              co;
        bit              ovf;
    } exp_t;

    exp_t sbq[$];
    st_t  sa, sb, sc;
    bit   mvalid;
    int   n_vec;
    int   n_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference counter written in modular integer arithmetic.
    function automatic st_t step(st_t s, bit rst, bit ld, bit ce, bit up, bit clr,
                                 longint unsigned d, longint unsigned m, longint unsigned rv);
        st_t n;
        bit  wrap;
        n     = s;
        n.co  = 1'b0;
        if (rst) begin
            n.q   = rv;
            n.ovf = 1'b0;
        end else if (ld) begin
            n.q = (d > m - 1) ? m - 1 : d;
            if (clr) n.ovf = 1'b0;
        end else if (ce) begin
            wrap  = up ? (s.q == m - 1) : (s.q == 0);
            n.q   = up ? (s.q + 1) % m : (s.q + m - 1) % m;
            n.co  = wrap;
            n.ovf = wrap | (s.ovf & ~clr);
        end else if (clr) begin
            n.ovf = 1'b0;
        end
        return n;
    endfunction

    function automatic bit tc_of(st_t s, bit ce, bit up, longint unsigned m);
        return ce && (up ? (s.q == m - 1) : (s.q == 0));
    endfunction

    function automatic exp_t mk(int id, st_t s);
        exp_t e;
        e.id  = id;
        e.q   = s.q;
        e.co  = s.co;
        e.ovf = s.ovf;
        return e;
    endfunction

    // Called just after a rising edge with inputs already driven; returns at the next rising edge.
    task automatic tick();
        exp_t e;
        #1;
        if (mvalid) begin
            check_eq("tc_a", ifa.tc, tc_of(sa, ifa.ce, ifa.up, 4096));
            check_eq("tc_b", ifb.tc, tc_of(sb, ifb.ce, ifb.up, 10));
        end
        sa = step(sa, rst_a, ifa.ld, ifa.ce, ifa.up, ifa.clr_ovf, ifa.d, 4096, 0);
        sb = step(sb, rst_b, ifb.ld, ifb.ce, ifb.up, ifb.clr_ovf, ifb.d, 10, 0);
        sc = step(sc, rst_c, 1'b0, iflo.ce, 1'b1, 1'b0, 0, 256, 0);
        sbq.push_back(mk(0, sa));
        sbq.push_back(mk(1, sb));
        sbq.push_back(mk(2, sc));
        @(negedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.id)
                0: begin
                    check_eq("a_q",   ifa.q,   e.q);
                    check_eq("a_co",  ifa.co,  e.co);
                    check_eq("a_ovf", ifa.ovf, e.ovf);
                end
                1: begin
                    check_eq("b_q",   ifb.q,   e.q);
                    check_eq("b_co",  ifb.co,  e.co);
                    check_eq("b_ovf", ifb.ovf, e.ovf);
                end
                default: begin
                    check_eq("c_q",   {ifhi.q, iflo.q}, e.q);
                    check_eq("c_co",  ifhi.co,  e.co);
                    check_eq("c_ovf", ifhi.ovf, e.ovf);
                end
            endcase
        end
        mvalid = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        mvalid = 1'b0;
        sa = '{0, 0, 0};
        sb = '{0, 0, 0};
        sc = '{0, 0, 0};
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ifa.ce = 1'b0; ifa.up = 1'b1; ifa.ld = 1'b0; ifa.d = '0; ifa.clr_ovf = 1'b0;
        ifb.ce = 1'b0; ifb.up = 1'b1; ifb.ld = 1'b0; ifb.d = '0; ifb.clr_ovf = 1'b0;
        iflo.ce = 1'b0; iflo.up = 1'b1; iflo.ld = 1'b0; iflo.d = '0; iflo.clr_ovf = 1'b0;
        ifhi.up = 1'b1; ifhi.ld = 1'b0; ifhi.d = '0; ifhi.clr_ovf = 1'b0;
        @(posedge clk);
        tick();
        tick();
        check_eq("rst_a_q", ifa.q, 0);
        check_eq("rst_b_q", ifb.q, 0);

        // 12-bit full-range count through one wrap.
        rst_a = 1'b0; ifa.ce = 1'b1; ifa.up = 1'b1;
        for (int i = 1; i <= 4097; i++) begin
            tick();
            if (i == 4095) begin
                check_eq("t1_top",  ifa.q,   12'hFFF);
                check_eq("t1_tc",   ifa.tc,  1);
                check_eq("t1_nov",  ifa.ovf, 0);
            end
            if (i == 4096) begin
                check_eq("t1_zero", ifa.q,   0);
                check_eq("t1_co",   ifa.co,  1);
                check_eq("t1_ovf",  ifa.ovf, 1);
            end
            if (i == 4097) begin
                check_eq("t1_one",  ifa.q,   1);
                check_eq("t1_co0",  ifa.co,  0);
                check_eq("t1_ovf1", ifa.ovf, 1);
            end
        end
        ifa.ce = 1'b0;

        // Modulo-10 down count from reset.
        rst_b = 1'b0; ifb.up = 1'b0; ifb.ce = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            tick();
            if (i == 1)  begin check_eq("t2_nine", ifb.q, 9); check_eq("t2_co", ifb.co, 1); end
            if (i == 10) begin check_eq("t2_zero", ifb.q, 0); check_eq("t2_tc", ifb.tc, 1); end
            if (i == 11) begin check_eq("t2_wrap", ifb.q, 9); check_eq("t2_co2", ifb.co, 1); end
        end

        // Loads, including the clamp, with ce asserted.
        rst_b = 1'b1; tick(); rst_b = 1'b0;
        ifb.up = 1'b1; ifb.ce = 1'b1; ifb.ld = 1'b1; ifb.d = 4'd7;
        tick();
        check_eq("t3_q7", ifb.q, 7); check_eq("t3_co", ifb.co, 0); check_eq("t3_ovf", ifb.ovf, 0);
        ifb.d = 4'd13;
        tick();
        check_eq("t3_clamp", ifb.q, 9); check_eq("t3_co2", ifb.co, 0); check_eq("t3_ovf2", ifb.ovf, 0);

        // Reset beats load at TOP; load beats count.
        rst_b = 1'b1; ifb.d = 4'd5;
        tick();
        check_eq("t4_rq", ifb.q, 0); check_eq("t4_rco", ifb.co, 0); check_eq("t4_rovf", ifb.ovf, 0);
        rst_b = 1'b0; ifb.ld = 1'b0;
        repeat (3) tick();
        check_eq("t4_q3", ifb.q, 3);
        ifb.ld = 1'b1;
        tick();
        check_eq("t4_ld5", ifb.q, 5); check_eq("t4_noco", ifb.co, 0);

        // Set wins over clr_ovf on a wrap edge; plain clr_ovf clears.
        ifb.ld = 1'b0;
        repeat (5) tick();
        repeat (9) tick();
        check_eq("t5_top", ifb.q, 9); check_eq("t5_ovf", ifb.ovf, 1);
        ifb.clr_ovf = 1'b1;
        tick();
        check_eq("t5_setwin", ifb.ovf, 1); check_eq("t5_q0", ifb.q, 0);
        tick();
        check_eq("t5_clr", ifb.ovf, 0); check_eq("t5_q1", ifb.q, 1);
        ifb.clr_ovf = 1'b0;

        // Random controls on the modulo-10 counter, including direction flips.
        for (int i = 0; i < 300; i++) begin
            rst_b       = ($urandom_range(0, 49) == 0);
            ifb.ld      = ($urandom_range(0, 9) == 0);
            ifb.ce      = ($urandom_range(0, 3) != 0);
            ifb.up      = $urandom_range(0, 1);
            ifb.clr_ovf = ($urandom_range(0, 7) == 0);
            ifb.d       = 4'($urandom_range(0, 15));
            tick();
        end
        rst_b = 1'b0; ifb.ld = 1'b0; ifb.ce = 1'b0; ifb.clr_ovf = 1'b0;

        // Two-stage cascade, 300 edges.
        rst_c = 1'b0; iflo.ce = 1'b1;
        repeat (300) tick();
        check_eq("t6_val", {ifhi.q, iflo.q}, 44);
        check_eq("t6_ovf", ifhi.ovf, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
